power_sequencer: RTL and testbench
==================================

Name: power_sequencer

Overview:
- Central power-up/power-down controller for the PMIC, replacing free-running per-stage good generation with an explicit sequence.
- Enables stage 1, stage 2 and stage 3 supplies in order, with one stage enable per output.
- Waits for each stage's good signal, from rail_good_generator-style inputs, to be stable before starting the next stage.
- Performs reverse-order shutdown on request or fault, with bounded automatic retries before lockout.

Parameters:
- SETTLE_CYCLES, 4160000: consecutive cycles a stage good must stay high before the next stage is enabled.
- TIMEOUT_CYCLES, 8320000: cycles allowed from stage enable to settle completion. Must be greater than SETTLE_CYCLES.
- OFF_DELAY_CYCLES, 416000: gap between successive stage disables during shutdown.
- RETRY_DELAY_CYCLES, 4160000: cooldown after a fault shutdown, before a retry.
- MAX_RETRIES, 3: automatic restart attempts before lockout. 0 means lock out on the first fault.

Ports:
- i_clk  in  1  system clock (4.16 MHz oscillator).
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  level request: 1 = power system up, 0 = orderly power down.
- i_s1Good  in  1  stage 1 all-rails-good.
- i_s2Good  in  1  stage 2 all-rails-good.
- i_s3Good  in  1  stage 3 all-rails-good.
- i_fault  in  1  OR of latched rail voltage/current faults.
- o_s1Enable  out  1  stage 1 supply enable.
- o_s2Enable  out  1  stage 2 supply enable.
- o_s3Enable  out  1  stage 3 supply enable.
- o_sysGood  out  1  high only in RUN.
- o_state  out  3  current state encoding.
- o_faultCode  out  3  last fault cause.
- o_retryCount  out  2  retries consumed.
- o_lockout  out  1  high in LOCKOUT.

Behaviour:
- All outputs are registered. On reset: state IDLE, all enables 0, o_sysGood 0, o_faultCode 0, o_retryCount 0, o_lockout 0, timers 0. Reset mid-sequence drops all enables on the next edge, with no ordered shutdown.
- States and encoding: IDLE 0, S1_UP 1, S2_UP 2, S3_UP 3, RUN 4, SHUTDOWN 5, COOLDOWN 6, LOCKOUT 7.
- Timers: one timeout timer and one settle counter, each reset to 0 on every state entry. Counter widths are $clog2(param+1). Counters saturate and never wrap.
- IDLE:
  - All enables 0. o_retryCount and o_faultCode are cleared on entry.
  - When i_enable=1, go to S1_UP.
- Sn_UP (n = 1..3):
  - o_snEnable is set on the entry edge. Lower-stage enables stay 1.
  - The settle counter increments while i_snGood=1 and clears to 0 whenever i_snGood=0.
  - When the settle counter reaches SETTLE_CYCLES, advance to the next Sn_UP, or to RUN from S3_UP.
  - If the timeout timer reaches TIMEOUT_CYCLES first, fault with code n.
- RUN:
  - o_sysGood=1. Any of i_s1Good, i_s2Good or i_s3Good low for even one cycle faults with code 4.
- Fault and shutdown triggers, evaluated in the UP states and RUN, in priority order:
  1. i_fault=1 → fault, code 5.
  2. Timeout or RUN rail loss → fault, codes 1-4 as above.
  3. i_enable=0 → orderly shutdown, no fault, o_faultCode unchanged.
- On fault:
  - o_faultCode is latched on the detecting edge, an internal fault flag is set, and the block enters SHUTDOWN.
  - o_sysGood drops on the same edge.
- SHUTDOWN:
  - Clear the highest currently-set enable on entry.
  - Each following enable is cleared OFF_DELAY_CYCLES after the previous one: S3, then S2, then S1. Stages never enabled are skipped.
  - OFF_DELAY_CYCLES after the last enable clears, go to COOLDOWN if the fault flag is set, otherwise to IDLE.
  - i_enable and i_fault are ignored while in SHUTDOWN.
- COOLDOWN:
  - Wait RETRY_DELAY_CYCLES.
  - If i_enable=0 at expiry, go to IDLE.
  - Else, if o_retryCount < MAX_RETRIES, increment o_retryCount, clear the fault flag and go to S1_UP.
  - Else go to LOCKOUT.
- LOCKOUT:
  - All enables 0, o_lockout=1, o_faultCode held.
  - Exit only via i_enable=0 (to IDLE) or reset.
- o_retryCount is cleared only on IDLE entry and reset; reaching RUN does not clear it.

Test Plan:
Test parameters: SETTLE 4, TIMEOUT 10, OFF_DELAY 3, RETRY 5, MAX_RETRIES 2.
1. Normal up: i_enable=1, each good asserted 2 cycles after its enable → enables rise in order S1, S2, S3, each 6 cycles apart; o_sysGood=1; o_state=4.
2. Orderly down from RUN: i_enable=0 → S3 drops, S2 drops 3 cycles later, S1 3 cycles after that; state goes to IDLE 3 cycles later; o_faultCode stays 0.
3. S2 timeout: i_s2Good held 0 → o_faultCode=2 10 cycles after o_s2Enable; reverse shutdown; COOLDOWN; retry with o_retryCount=1.
4. Glitchy good: i_s1Good toggles 1,1,1,0,1,1,1,1 → settle restarts at the 0; S2 enable follows the 4th consecutive high cycle.
5. Persistent i_fault in RUN: o_faultCode=5; two retries each fail; o_lockout=1, o_retryCount=2; i_enable=0 → IDLE, retry count 0.
6. i_reset asserted in S3_UP: all enables 0 and state 0 on the next edge.

Source files
------------

// File: rtl/power_sequencer.sv
// -----------------------------------------------------------------------------
// power_sequencer
//
// Central power-up / power-down controller for the PMIC. Brings the three
// supply stages up in order (S1, S2, S3), requiring each stage's good signal
// to stay high for SETTLE_CYCLES consecutive cycles before enabling the next
// one. Shuts the stages down in reverse order, with OFF_DELAY_CYCLES between
// disables, either on request or on a fault. After a fault it cools down for
// RETRY_DELAY_CYCLES and retries, up to MAX_RETRIES times, then locks out.
//
// Ports:
//   i_clk         system clock (4.16 MHz oscillator)
//   i_reset       synchronous, active-high reset
//   i_enable      level request: 1 = power up, 0 = orderly power down
//   i_s1Good      stage 1 all-rails-good
//   i_s2Good      stage 2 all-rails-good
//   i_s3Good      stage 3 all-rails-good
//   i_fault       OR of latched rail voltage/current faults
//   o_s1Enable    stage 1 supply enable
//   o_s2Enable    stage 2 supply enable
//   o_s3Enable    stage 3 supply enable
//   o_sysGood     high only in RUN
//   o_state       current state encoding (IDLE=0 .. LOCKOUT=7)
//   o_faultCode   last fault cause (1-3 stage timeout, 4 rail loss, 5 fault)
//   o_retryCount  automatic retries consumed
//   o_lockout     high in LOCKOUT
// -----------------------------------------------------------------------------
module power_sequencer #(
    parameter int unsigned SETTLE_CYCLES      = 4160000,
    parameter int unsigned TIMEOUT_CYCLES     = 8320000,
    parameter int unsigned OFF_DELAY_CYCLES   = 416000,
    parameter int unsigned RETRY_DELAY_CYCLES = 4160000,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_s1Good,
    input  logic       i_s2Good,
    input  logic       i_s3Good,
    input  logic       i_fault,
    output logic       o_s1Enable,
    output logic       o_s2Enable,
    output logic       o_s3Enable,
    output logic       o_sysGood,
    output logic [2:0] o_state,
    output logic [2:0] o_faultCode,
    output logic [1:0] o_retryCount,
    output logic       o_lockout
);

    // The single timer serves the stage timeout, the shutdown gap and the
    // retry cooldown, so it is sized for the largest of the three.
    localparam int unsigned TMR_MAX_I =
        (TIMEOUT_CYCLES > RETRY_DELAY_CYCLES)
            ? ((TIMEOUT_CYCLES > OFF_DELAY_CYCLES) ? TIMEOUT_CYCLES : OFF_DELAY_CYCLES)
            : ((RETRY_DELAY_CYCLES > OFF_DELAY_CYCLES) ? RETRY_DELAY_CYCLES : OFF_DELAY_CYCLES);
    localparam int TMR_W = $clog2(TMR_MAX_I + 1);
    localparam int STL_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_MAX     = TMR_W'(TMR_MAX_I);
    localparam logic [TMR_W-1:0] TIMEOUT_T   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] OFF_T       = TMR_W'(OFF_DELAY_CYCLES);
    localparam logic [TMR_W-1:0] RETRY_T     = TMR_W'(RETRY_DELAY_CYCLES);
    localparam logic [STL_W-1:0] STL_MAX     = STL_W'(SETTLE_CYCLES);
    localparam logic [STL_W-1:0] SETTLE_T    = STL_W'(SETTLE_CYCLES);
    localparam logic [1:0]       MAX_RETRY_T = 2'(MAX_RETRIES);

    localparam logic [2:0] FC_NONE  = 3'd0;
    localparam logic [2:0] FC_RAIL  = 3'd4;
    localparam logic [2:0] FC_FAULT = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_S1_UP    = 3'd1,
        ST_S2_UP    = 3'd2,
        ST_S3_UP    = 3'd3,
        ST_RUN      = 3'd4,
        ST_SHUTDOWN = 3'd5,
        ST_COOLDOWN = 3'd6,
        ST_LOCKOUT  = 3'd7
    } state_t;

    // Registered state
    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [STL_W-1:0] r_settle;
    logic [2:0]       r_enable;      // bit 0 = stage 1 ... bit 2 = stage 3
    logic             r_sys_good;
    logic [2:0]       r_fault_code;
    logic [1:0]       r_retry;
    logic             r_lockout;
    logic             r_fault_flag;  // shutdown was caused by a fault

    // Next-state values
    state_t           w_state;
    logic [TMR_W-1:0] w_timer;
    logic [STL_W-1:0] w_settle;
    logic [2:0]       w_enable;
    logic [2:0]       w_fault_code;
    logic [1:0]       w_retry;
    logic             w_fault_flag;
    logic             w_go_fault;
    logic             w_go_down;
    logic [2:0]       w_code;

    // Shared helpers
    logic [TMR_W-1:0] w_timer_inc;
    logic [STL_W-1:0] w_settle_inc;
    logic [STL_W-1:0] w_settle_run;
    logic             w_stage_good;
    logic             w_settled;
    logic             w_timed_out;
    logic             w_all_good;

    // Counters saturate instead of wrapping.
    assign w_timer_inc  = (r_timer == TMR_MAX)  ? r_timer  : r_timer + TMR_W'(1);
    assign w_settle_inc = (r_settle == STL_MAX) ? r_settle : r_settle + STL_W'(1);

    // Good signal of the stage currently being brought up.
    assign w_stage_good = (r_state == ST_S1_UP) ? i_s1Good :
                          (r_state == ST_S2_UP) ? i_s2Good : i_s3Good;

    // Settle count after this edge: restarts on any low cycle of the good.
    assign w_settle_run = w_stage_good ? w_settle_inc : '0;
    assign w_settled    = (w_settle_run >= SETTLE_T);
    assign w_timed_out  = (w_timer_inc >= TIMEOUT_T);
    assign w_all_good   = i_s1Good & i_s2Good & i_s3Good;

    // Clears the highest stage enable that is currently set.
    function automatic logic [2:0] drop_highest(input logic [2:0] en);
        if (en[2])      return {1'b0, en[1:0]};
        else if (en[1]) return {2'b00, en[0]};
        else            return 3'b000;
    endfunction

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_state      = r_state;
        w_timer      = r_timer;
        w_settle     = r_settle;
        w_enable     = r_enable;
        w_fault_code = r_fault_code;
        w_retry      = r_retry;
        w_fault_flag = r_fault_flag;
        w_go_fault   = 1'b0;
        w_go_down    = 1'b0;
        w_code       = FC_NONE;

        case (r_state)
            ST_IDLE: begin
                if (i_enable) begin
                    w_state  = ST_S1_UP;
                    w_enable = 3'b001;
                end
            end

            ST_S1_UP, ST_S2_UP, ST_S3_UP: begin
                w_timer  = w_timer_inc;
                w_settle = w_settle_run;
                if (i_fault) begin
                    w_go_fault = 1'b1;
                    w_code     = FC_FAULT;
                end else if (w_timed_out && !w_settled) begin
                    // A good that settles on the very edge the timeout
                    // expires still counts as settled in time.
                    w_go_fault = 1'b1;
                    // Timeout code equals the stage number, which is also
                    // the low bits of the Sn_UP encoding.
                    w_code     = {1'b0, r_state[1:0]};
                end else if (!i_enable) begin
                    w_go_down = 1'b1;
                end else if (w_settled) begin
                    case (r_state)
                        ST_S1_UP: begin
                            w_state  = ST_S2_UP;
                            w_enable = r_enable | 3'b010;
                        end
                        ST_S2_UP: begin
                            w_state  = ST_S3_UP;
                            w_enable = r_enable | 3'b100;
                        end
                        default: w_state = ST_RUN;
                    endcase
                end
            end

            ST_RUN: begin
                if (i_fault) begin
                    w_go_fault = 1'b1;
                    w_code     = FC_FAULT;
                end else if (!w_all_good) begin
                    w_go_fault = 1'b1;
                    w_code     = FC_RAIL;
                end else if (!i_enable) begin
                    w_go_down = 1'b1;
                end
            end

            ST_SHUTDOWN: begin
                // i_enable and i_fault are deliberately ignored here.
                w_timer = w_timer_inc;
                if (w_timer_inc >= OFF_T) begin
                    w_timer = '0;
                    if (r_enable != 3'b000) begin
                        w_enable = drop_highest(r_enable);
                    end else begin
                        w_state = r_fault_flag ? ST_COOLDOWN : ST_IDLE;
                    end
                end
            end

            ST_COOLDOWN: begin
                w_timer = w_timer_inc;
                if (w_timer_inc >= RETRY_T) begin
                    if (!i_enable) begin
                        w_state = ST_IDLE;
                    end else if (r_retry < MAX_RETRY_T) begin
                        w_retry      = r_retry + 2'd1;
                        w_fault_flag = 1'b0;
                        w_state      = ST_S1_UP;
                        w_enable     = 3'b001;
                    end else begin
                        w_state = ST_LOCKOUT;
                    end
                end
            end

            ST_LOCKOUT: begin
                w_enable = 3'b000;
                if (!i_enable) w_state = ST_IDLE;
            end

            default: w_state = ST_IDLE;
        endcase

        if (w_go_fault) begin
            w_fault_code = w_code;
            w_fault_flag = 1'b1;
        end

        // Fault or request both start the reverse-order shutdown; the highest
        // enable goes on the same edge.
        if (w_go_fault || w_go_down) begin
            w_state  = ST_SHUTDOWN;
            w_enable = drop_highest(r_enable);
        end

        if (w_state != r_state) begin
            w_timer  = '0;
            w_settle = '0;
        end

        if (w_state == ST_IDLE) begin
            w_enable     = 3'b000;
            w_fault_code = FC_NONE;
            w_retry      = 2'd0;
            w_fault_flag = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_settle     <= '0;
            r_enable     <= 3'b000;
            r_sys_good   <= 1'b0;
            r_fault_code <= FC_NONE;
            r_retry      <= 2'd0;
            r_lockout    <= 1'b0;
            r_fault_flag <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_timer      <= w_timer;
            r_settle     <= w_settle;
            r_enable     <= w_enable;
            r_sys_good   <= (w_state == ST_RUN);
            r_fault_code <= w_fault_code;
            r_retry      <= w_retry;
            r_lockout    <= (w_state == ST_LOCKOUT);
            r_fault_flag <= w_fault_flag;
        end
    end

    assign o_s1Enable   = r_enable[0];
    assign o_s2Enable   = r_enable[1];
    assign o_s3Enable   = r_enable[2];
    assign o_sysGood    = r_sys_good;
    assign o_state      = r_state;
    assign o_faultCode  = r_fault_code;
    assign o_retryCount = r_retry;
    assign o_lockout    = r_lockout;

endmodule

// File: tb/tb_power_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_power_sequencer
//
// Behavioural model of the sequencer (stage level + phase counters) compared
// against every DUT output on every falling edge, plus directed scenarios
// with hand-computed timing expectations and a randomized phase.
// -----------------------------------------------------------------------------
module tb_power_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 10;
    localparam int OFFD    = 3;
    localparam int RETRY   = 5;
    localparam int MAXR    = 2;

    // wait_for() condition selectors
    localparam int W_S1_ON   = 1;
    localparam int W_S2_ON   = 2;
    localparam int W_S3_ON   = 3;
    localparam int W_RUN     = 4;
    localparam int W_S3_OFF  = 5;
    localparam int W_S2_OFF  = 6;
    localparam int W_S1_OFF  = 7;
    localparam int W_IDLE    = 8;
    localparam int W_CODE2   = 9;
    localparam int W_COOL    = 10;
    localparam int W_S1_UP   = 11;
    localparam int W_LOCK    = 12;
    localparam int W_S3_UP   = 13;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       s1g = 1'b0, s2g = 1'b0, s3g = 1'b0;
    logic       fault = 1'b0;
    logic       o_s1Enable, o_s2Enable, o_s3Enable, o_sysGood, o_lockout;
    logic [2:0] o_state, o_faultCode;
    logic [1:0] o_retryCount;

    always #5 clk = ~clk;

    power_sequencer #(
        .SETTLE_CYCLES     (SETTLE),
        .TIMEOUT_CYCLES    (TIMEOUT),
        .OFF_DELAY_CYCLES  (OFFD),
        .RETRY_DELAY_CYCLES(RETRY),
        .MAX_RETRIES       (MAXR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_enable    (enable),
        .i_s1Good    (s1g),
        .i_s2Good    (s2g),
        .i_s3Good    (s3g),
        .i_fault     (fault),
        .o_s1Enable  (o_s1Enable),
        .o_s2Enable  (o_s2Enable),
        .o_s3Enable  (o_s3Enable),
        .o_sysGood   (o_sysGood),
        .o_state     (o_state),
        .o_faultCode (o_faultCode),
        .o_retryCount(o_retryCount),
        .o_lockout   (o_lockout)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- model
    // Phase numbers follow the published state encoding; m_lvl is how many
    // stages are powered (stages are always powered as a prefix S1..Sn).
    int m_st, m_lvl, m_tmr, m_stl, m_code, m_retry, m_flag;
    bit m_valid = 1'b0;

    task automatic m_go_idle();
        m_st = 0; m_lvl = 0; m_tmr = 0; m_stl = 0;
        m_code = 0; m_retry = 0; m_flag = 0;
    endtask

    task automatic m_enter_up(input int n);
        m_st = n; m_lvl = n; m_tmr = 0; m_stl = 0;
    endtask

    task automatic m_start_off();
        m_st = 5; m_lvl = m_lvl - 1; m_tmr = 0; m_stl = 0;
    endtask

    task automatic m_fault(input int code);
        m_code = code; m_flag = 1;
        m_start_off();
    endtask

    task automatic model_step(input bit rst, input bit en, input bit flt,
                              input bit g1, input bit g2, input bit g3);
        bit g [1:3];
        bit settled, timed;
        g[1] = g1; g[2] = g2; g[3] = g3;
        if (rst) begin
            m_go_idle();
            return;
        end
        case (m_st)
            0: if (en) m_enter_up(1);
            1, 2, 3: begin
                m_tmr++;
                m_stl   = g[m_st] ? m_stl + 1 : 0;
                settled = (m_stl >= SETTLE);
                timed   = (m_tmr >= TIMEOUT);
                if (flt)                    m_fault(5);
                else if (timed && !settled) m_fault(m_st);
                else if (!en)               m_start_off();
                else if (settled) begin
                    if (m_st < 3) m_enter_up(m_st + 1);
                    else begin m_st = 4; m_tmr = 0; m_stl = 0; end
                end
            end
            4: begin
                if (flt)                    m_fault(5);
                else if (!(g1 && g2 && g3)) m_fault(4);
                else if (!en)               m_start_off();
            end
            5: begin
                m_tmr++;
                if (m_tmr >= OFFD) begin
                    m_tmr = 0;
                    if (m_lvl > 0)   m_lvl--;
                    else if (m_flag) m_st = 6;
                    else             m_go_idle();
                end
            end
            6: begin
                m_tmr++;
                if (m_tmr >= RETRY) begin
                    m_tmr = 0;
                    if (!en) m_go_idle();
                    else if (m_retry < MAXR) begin
                        m_retry++; m_flag = 0; m_enter_up(1);
                    end else begin
                        m_st = 7; m_lvl = 0;
                    end
                end
            end
            default: if (!en) m_go_idle();
        endcase
    endtask

    function automatic logic [12:0] model_vec();
        return {m_lvl >= 3, m_lvl >= 2, m_lvl >= 1, m_st == 4, 3'(m_st),
                3'(m_code), 2'(m_retry), m_st == 7};
    endfunction

    logic [12:0] dut_vec;
    assign dut_vec = {o_s3Enable, o_s2Enable, o_s1Enable, o_sysGood, o_state,
                      o_faultCode, o_retryCount, o_lockout};

    always @(posedge clk) begin
        cyc++;
        model_step(reset, enable, fault, s1g, s2g, s3g);
        if (reset) m_valid = 1'b1;
    end

    // Single compare process: all outputs, every cycle.
    always @(negedge clk) begin
        if (m_valid) check("outputs{en3,en2,en1,good,state,code,retry,lock}", dut_vec, model_vec());
    end

    // ---------------------------------------------------------------- plant
    // Mode 0: good follows its enable two clocks late. 1: stuck low.
    // 2: as 0 with random one-cycle dropouts. 3: as 0 but the first eight
    // cycles follow pat[].
    int pmode [1:3] = '{0, 0, 0};
    int pcnt  [1:3] = '{0, 0, 0};
    int pat   [8]   = '{1, 1, 1, 0, 1, 1, 1, 1};
    bit gv    [1:3];
    bit env   [1:3];

    always @(negedge clk) begin
        env[1] = o_s1Enable; env[2] = o_s2Enable; env[3] = o_s3Enable;
        for (int n = 1; n <= 3; n++) begin
            pcnt[n] = env[n] ? pcnt[n] + 1 : 0;
            case (pmode[n])
                0:       gv[n] = env[n] && pcnt[n] >= 3;
                1:       gv[n] = 1'b0;
                2:       gv[n] = env[n] && pcnt[n] >= 3 && ($urandom_range(0, 7) != 0);
                default: gv[n] = env[n] && pcnt[n] >= 3 &&
                                 ((pcnt[n] - 3 >= 8) || (pat[pcnt[n] - 3] != 0));
            endcase
        end
        s1g = gv[1]; s2g = gv[2]; s3g = gv[3];
    end

    // ---------------------------------------------------------------- helpers
    task automatic wait_for(input int what, input int budget, input string name, output int at);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            case (what)
                W_S1_ON:  hit = o_s1Enable;
                W_S2_ON:  hit = o_s2Enable;
                W_S3_ON:  hit = o_s3Enable;
                W_RUN:    hit = (o_state == 3'd4);
                W_S3_OFF: hit = !o_s3Enable;
                W_S2_OFF: hit = !o_s2Enable;
                W_S1_OFF: hit = !o_s1Enable;
                W_IDLE:   hit = (o_state == 3'd0);
                W_CODE2:  hit = (o_faultCode == 3'd2);
                W_COOL:   hit = (o_state == 3'd6);
                W_S1_UP:  hit = (o_state == 3'd1);
                W_LOCK:   hit = o_lockout;
                W_S3_UP:  hit = (o_state == 3'd3);
                default:  hit = 1'b0;
            endcase
        end
        check({"reach_", name}, 32'(hit), 32'd1);
        at = cyc;
    endtask

    int t_a, t_b, t_c, t_d;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        check("reset_all_outputs", 32'(dut_vec), 32'd0);
        reset = 1'b0;

        // 1. Normal power-up
        enable = 1'b1;
        wait_for(W_S1_ON, 10, "s1_on", t_a);
        wait_for(W_S2_ON, 30, "s2_on", t_b);
        wait_for(W_S3_ON, 30, "s3_on", t_c);
        check("up_gap_s1_s2", 32'(t_b - t_a), 32'd6);
        check("up_gap_s2_s3", 32'(t_c - t_b), 32'd6);
        wait_for(W_RUN, 30, "run", t_d);
        check("run_state", 32'(o_state), 32'd4);
        check("run_sysgood", 32'(o_sysGood), 32'd1);

        // 2. Orderly shutdown from RUN
        enable = 1'b0;
        wait_for(W_S3_OFF, 5, "s3_off", t_a);
        wait_for(W_S2_OFF, 10, "s2_off", t_b);
        wait_for(W_S1_OFF, 10, "s1_off", t_c);
        wait_for(W_IDLE, 10, "idle_after_down", t_d);
        check("down_gap_s3_s2", 32'(t_b - t_a), 32'd3);
        check("down_gap_s2_s1", 32'(t_c - t_b), 32'd3);
        check("down_gap_s1_idle", 32'(t_d - t_c), 32'd3);
        check("down_faultcode", 32'(o_faultCode), 32'd0);

        // 3. Stage 2 timeout, shutdown, cooldown, retry
        pmode[2] = 1;
        @(negedge clk);
        enable = 1'b1;
        wait_for(W_S2_ON, 30, "s2_on_to", t_a);
        wait_for(W_CODE2, 30, "code2", t_b);
        check("timeout_latency", 32'(t_b - t_a), 32'd10);
        check("timeout_state", 32'(o_state), 32'd5);
        check("timeout_s2_dropped", 32'(o_s2Enable), 32'd0);
        wait_for(W_COOL, 30, "cooldown", t_c);
        wait_for(W_S1_UP, 30, "retry", t_d);
        check("retry_count_1", 32'(o_retryCount), 32'd1);
        check("retry_code_held", 32'(o_faultCode), 32'd2);
        enable = 1'b0;
        pmode[2] = 0;
        wait_for(W_IDLE, 50, "idle_after_timeout", t_d);

        // 4. Glitchy stage 1 good
        pmode[1] = 3;
        @(negedge clk);
        enable = 1'b1;
        wait_for(W_S1_ON, 10, "s1_on_glitch", t_a);
        wait_for(W_S2_ON, 30, "s2_on_glitch", t_b);
        check("glitch_s2_latency", 32'(t_b - t_a), 32'd10);
        wait_for(W_RUN, 40, "run_glitch", t_c);
        enable = 1'b0;
        wait_for(W_IDLE, 40, "idle_after_glitch", t_d);
        pmode[1] = 0;

        // 5. Persistent fault in RUN -> retries -> lockout
        @(negedge clk);
        enable = 1'b1;
        wait_for(W_RUN, 60, "run_before_fault", t_a);
        fault = 1'b1;
        wait_for(W_LOCK, 200, "lockout", t_b);
        check("lock_code", 32'(o_faultCode), 32'd5);
        check("lock_retries", 32'(o_retryCount), 32'd2);
        check("lock_state", 32'(o_state), 32'd7);
        check("lock_enables", 32'({o_s3Enable, o_s2Enable, o_s1Enable}), 32'd0);
        enable = 1'b0;
        wait_for(W_IDLE, 10, "idle_after_lock", t_c);
        fault = 1'b0;
        check("unlock_retries", 32'(o_retryCount), 32'd0);
        check("unlock_code", 32'(o_faultCode), 32'd0);
        check("unlock_lockout", 32'(o_lockout), 32'd0);

        // 6. Reset in S3_UP
        @(negedge clk);
        enable = 1'b1;
        wait_for(W_S3_UP, 60, "s3_up", t_a);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_state", 32'(o_state), 32'd0);
        check("reset_mid_enables", 32'({o_s3Enable, o_s2Enable, o_s1Enable}), 32'd0);
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);

        // Randomized phase
        for (int ep = 0; ep < 40; ep++) begin
            int len;
            for (int n = 1; n <= 3; n++) begin
                int r;
                r = $urandom_range(0, 9);
                pmode[n] = (r < 7) ? 0 : (r < 8) ? 1 : 2;
            end
            enable = ($urandom_range(0, 4) != 0);
            len = $urandom_range(10, 90);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                fault = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 49) == 0) enable = ~enable;
                reset = ($urandom_range(0, 299) == 0);
            end
        end
        reset = 1'b0;
        fault = 1'b0;
        enable = 1'b0;
        for (int n = 1; n <= 3; n++) pmode[n] = 0;
        repeat (60) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
